// File: rtl/alu_in_reg.sv
// rtl/alu_in_reg.sv - two-entry operand buffer feeding the ALU core over valid/ready
module alu_in_reg #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_carry,
  input  logic             flush,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_carry,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] skid_a;
  logic [WIDTH-1:0] skid_b;
  logic [OPW-1:0]   skid_op;
  logic             skid_carry;

  logic       accept;
  logic       pop;
  logic       load_head;
  logic       load_skid;
  logic       shift;
  logic [1:0] cnt_nxt;

  assign accept = in_valid & in_ready;
  assign pop    = alu_valid & alu_ready;

  // The head is refilled straight from the input whenever it is empty or is
  // being vacated in the same cycle; the skid only holds the second word.
  assign load_head = accept & ((count == 2'd0) | ((count == 2'd1) & pop));
  assign load_skid = accept & (count == 2'd1) & ~pop;
  assign shift     = pop & (count == 2'd2);

  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt_nxt = count + 2'd1;
        2'b01:   cnt_nxt = count - 2'd1;
        default: cnt_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      alu_valid  <= 1'b0;
      in_ready   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_carry  <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_op    <= '0;
      skid_carry <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      alu_valid <= (cnt_nxt != 2'd0);
      in_ready  <= (cnt_nxt < 2'd2);
      // Flush only clears occupancy; the head fields keep their last value.
      if (!flush) begin
        if (load_head) begin
          alu_a     <= in_a;
          alu_b     <= in_b;
          alu_op    <= in_op;
          alu_carry <= in_carry;
        end else if (shift) begin
          alu_a     <= skid_a;
          alu_b     <= skid_b;
          alu_op    <= skid_op;
          alu_carry <= skid_carry;
        end
        if (load_skid) begin
          skid_a     <= in_a;
          skid_b     <= in_b;
          skid_op    <= in_op;
          skid_carry <= in_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_in_reg.sv
// tb/tb_alu_in_reg.sv - randomized and directed bench for alu_in_reg against a queue model
module tb_alu_in_reg;
  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             in_carry;
  logic             flush;
  logic             alu_valid;
  logic             alu_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_carry;
  logic [1:0]       count;

  always #5 clk_in = ~clk_in;

  alu_in_reg #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_carry(in_carry),
    .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry(alu_carry),
    .count(count)
  );

  typedef logic [2*WIDTH+OPW:0] word_t;

  int    tests = 0;
  int    fails = 0;
  word_t q[$];
  word_t last_head;
  logic  exp_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t in_word();
    return {in_a, in_b, in_op, in_carry};
  endfunction

  // Reference: an ordered queue of at most two words, updated once per edge.
  task automatic model_edge();
    bit acc;
    bit pop;
    if (!rst_n) begin
      q.delete();
      exp_ready = 1'b0;
      last_head = '0;
      return;
    end
    acc = in_valid && exp_ready;
    pop = alu_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(in_word());
    end
    if (q.size() > 0) last_head = q[0];
    exp_ready = (q.size() < 2);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, alu_valid, q.size() != 0);
    check({tag, ".ready"}, in_ready, exp_ready);
    check({tag, ".count"}, count, q.size());
    check({tag, ".head"}, {alu_a, alu_b, alu_op, alu_carry}, last_head);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_in);
    model_edge();
    #2;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic r, input logic f);
    in_valid  = v;
    alu_ready = r;
    flush     = f;
  endtask

  task automatic rand_word();
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_op    = OPW'($urandom);
    in_carry = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    in_a = '0; in_b = '0; in_op = '0; in_carry = 1'b0;
    #1 rst_n = 1'b0;
    model_edge();

    // Reset held for three cycles, then released between edges.
    repeat (3) cycle("reset");
    rst_n = 1'b1;
    #1 check("ready_before_edge", in_ready, 1'b0);
    cycle("release");

    // Single operation.
    in_a = 8'h3C; in_b = 8'h05; in_op = 4'h2; in_carry = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    cycle("single_acc");
    check("single_a", alu_a, 8'h3C);
    check("single_b", alu_b, 8'h05);
    check("single_op", alu_op, 4'h2);
    check("single_c", alu_carry, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    cycle("single_pop");

    // Back-pressure with three words offered.
    drive(1'b1, 1'b0, 1'b0);
    in_a = 8'h11; cycle("bp_w1");
    in_a = 8'h22; cycle("bp_w2");
    in_a = 8'h33; cycle("bp_w3_held");
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_full_count", count, 2'd2);
    alu_ready = 1'b1;
    cycle("bp_pop1");
    check("bp_head_w2", alu_a, 8'h22);
    cycle("bp_pop2");
    check("bp_head_w3", alu_a, 8'h33);
    in_valid = 1'b0;
    cycle("bp_pop3");

    // Streaming, one word per cycle.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_a = WIDTH'(i + 8'h40);
      cycle("stream");
    end
    in_valid = 1'b0;
    cycle("stream_drain");

    // Flush while full with a word offered.
    drive(1'b1, 1'b0, 1'b0);
    rand_word(); cycle("fl_w1");
    rand_word(); cycle("fl_w2");
    rand_word();
    flush = 1'b1;
    cycle("flush");
    check("flush_count", count, 2'd0);
    drive(1'b0, 1'b1, 1'b0);
    cycle("post_flush");

    // Asynchronous reset while full.
    drive(1'b1, 1'b0, 1'b0);
    rand_word(); cycle("rs_w1");
    rand_word(); cycle("rs_w2");
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    model_edge();
    #1;
    check("async_valid", alu_valid, 1'b0);
    check("async_count", count, 2'd0);
    check_all("async_rst");
    #1 rst_n = 1'b1;
    cycle("rs_release");
    drive(1'b1, 1'b1, 1'b0);
    rand_word(); cycle("rs_new");
    in_valid = 1'b0;
    cycle("rs_drain");

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      rand_word();
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
